// File: rtl/keypad_pkg.sv
// Shared types and key-map lookup for the 4x4 keypad emulator and the scanner/decoder bench.
package keypad_pkg;

    localparam logic [3:0] ROW_IDLE = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_HELD,
        ST_BOUNCE_OUT,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } key_pos_t;

    // Hex key code to its (column, row index) position on the matrix.
    function automatic key_pos_t key_lookup(input logic [3:0] code);
        key_pos_t p;
        p = '0;
        case (code)
            4'h1: p = '{col: 2'd0, row: 2'd0};
            4'h4: p = '{col: 2'd0, row: 2'd1};
            4'h7: p = '{col: 2'd0, row: 2'd2};
            4'hA: p = '{col: 2'd0, row: 2'd3};
            4'h2: p = '{col: 2'd1, row: 2'd0};
            4'h5: p = '{col: 2'd1, row: 2'd1};
            4'h8: p = '{col: 2'd1, row: 2'd2};
            4'h0: p = '{col: 2'd1, row: 2'd3};
            4'h3: p = '{col: 2'd2, row: 2'd0};
            4'h6: p = '{col: 2'd2, row: 2'd1};
            4'h9: p = '{col: 2'd2, row: 2'd2};
            4'hB: p = '{col: 2'd2, row: 2'd3};
            4'hF: p = '{col: 2'd3, row: 2'd0};
            4'hE: p = '{col: 2'd3, row: 2'd1};
            4'hD: p = '{col: 2'd3, row: 2'd2};
            4'hC: p = '{col: 2'd3, row: 2'd3};
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/keypad_bounce_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) supplying pseudo-random contact chatter during bounce.
module keypad_bounce_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic bit_out
);

    localparam logic [15:0] TAPS = 16'hB400;

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (enable) begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
        end
    end

    assign bit_out = lfsr_q[0];

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: presses a requested key and drives active-low rows for the scanned column.
// Optional contact bounce on make/break edges is enabled with `define KEYPAD_BOUNCE_EN.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES  = 64,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned BOUNCE_CYCLES = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [1:0] col,
    output logic [0:3] row,
    output logic       busy,
    output logic       done
);

    localparam int unsigned MAX_PG     = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_PG > BOUNCE_CYCLES) ? MAX_PG : BOUNCE_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
`ifdef KEYPAD_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
`endif

    // Reject parameter values the counter scheme cannot represent.
    if (PRESS_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("keypad_emulator: cycle parameters must be >= 1");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("keypad_emulator: LFSR_SEED must be non-zero");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q;
    logic [0:3]       row_d;
    logic             busy_d, ready_d, done_d;
    logic             accept;
    logic             contact;
    key_pos_t         pos;

`ifdef KEYPAD_BOUNCE_EN
    logic lfsr_en;
    logic lfsr_bit;

    assign lfsr_en = (state_q == ST_BOUNCE_IN) || (state_q == ST_BOUNCE_OUT);

    keypad_bounce_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (lfsr_en),
        .bit_out(lfsr_bit)
    );
`endif

    assign accept = key_valid && key_ready;

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        contact = 1'b0;
        pos     = key_lookup(code_q);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef KEYPAD_BOUNCE_EN
                    state_d = ST_BOUNCE_IN;
                    cnt_d   = BOUNCE_LOAD;
`else
                    state_d = ST_HELD;
                    cnt_d   = PRESS_LOAD;
`endif
                end
            end
`ifdef KEYPAD_BOUNCE_EN
            ST_BOUNCE_IN: begin
                contact = lfsr_bit;
                if (cnt_q == '0) begin
                    state_d = ST_HELD;
                    cnt_d   = PRESS_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_BOUNCE_OUT: begin
                contact = lfsr_bit;
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            ST_HELD: begin
                contact = 1'b1;
                if (cnt_q == '0) begin
`ifdef KEYPAD_BOUNCE_EN
                    state_d = ST_BOUNCE_OUT;
                    cnt_d   = BOUNCE_LOAD;
`else
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        row_d = ROW_IDLE;
        if (contact && (col == pos.col)) begin
            row_d[pos.row] = 1'b0;
        end

        // Outputs are decoded from the next state so they line up with the state register.
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_GAP) && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            code_q    <= '0;
            row       <= ROW_IDLE;
            key_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row       <= row_d;
            key_ready <= ready_d;
            busy      <= busy_d;
            done      <= done_d;
            if (accept) begin
                code_q <= key_code;
            end
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator; inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_keypad_emulator;

    localparam int P = 8;
    localparam int G = 4;
    localparam int B = 3;
`ifdef KEYPAD_BOUNCE_EN
    localparam int OFF = B;
`else
    localparam int OFF = 0;
`endif
    localparam int TOT = P + G + 2 * OFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_ready;
    logic [1:0] col = 2'd0;
    logic [0:3] row;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference key map, indexed [column][row index].
    int keymap [0:3][0:3] = '{'{1, 4, 7, 10}, '{2, 5, 8, 0}, '{3, 6, 9, 11}, '{15, 14, 13, 12}};

    keypad_emulator #(
        .PRESS_CYCLES (P),
        .GAP_CYCLES   (G),
        .BOUNCE_CYCLES(B),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .col      (col),
        .row      (row),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [0:3] row_for(input int code, input int c);
        logic [0:3] p;
        p = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (keymap[c][r] == code) p[r] = 1'b0;
        end
        return p;
    endfunction

    // j is the cycle index (after accept) whose contact state produces the row seen one cycle later.
    function automatic bit held(input int j);
        return (j >= OFF + 1) && (j <= OFF + P);
    endfunction

    function automatic bit in_bounce(input int j);
        return (OFF > 0) && (((j >= 1) && (j <= OFF)) || ((j >= OFF + P + 1) && (j <= 2 * OFF + P)));
    endfunction

    // Request a key in the current idle cycle; returns on the falling edge of the first cycle after accept.
    task automatic start_press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_ready === 1'b1 && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle timeout key_ready=%b busy=%b expected 1/0", key_ready, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (row !== 4'b1111 || busy !== 1'b0 || key_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state row=%b busy=%b ready=%b done=%b expected 1111/0/1/0", row, busy, key_ready, done);
        end
        rst_n = 1'b1;
        col = 2'd1;
        start_press(4'h5);
        repeat (OFF + 3) @(negedge clk);
        checks++;
        if (row !== 4'b1011) begin
            errors++;
            $display("FAIL reset_pre_held row=%b expected 1011", row);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (row !== 4'b1111 || busy !== 1'b0 || key_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async row=%b busy=%b ready=%b done=%b expected 1111/0/1/0", row, busy, key_ready, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < P + G + 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || row !== 4'b1111) begin
                errors++;
                $display("FAIL reset_after k=%0d done=%b busy=%b row=%b expected 0/0/1111", k, done, busy, row);
            end
        end
    endtask

    task automatic test_hold();
        logic [0:3] exp;
        logic [1:0] colprev;
        int lows;
        lows = 0;
        wait_idle();
        col = 2'd1;
        colprev = col;
        start_press(4'h5);
        for (int k = 1; k <= P + OFF + 3; k++) begin
            exp = (held(k - 1) && colprev == 2'd1) ? row_for(5, 1) : 4'b1111;
            if (!in_bounce(k - 1)) begin
                checks++;
                if (row !== exp) begin
                    errors++;
                    $display("FAIL hold_row k=%0d row=%b expected %b", k, row, exp);
                end
            end
            if (held(k - 1) && row === 4'b1011) lows++;
            if (k == OFF + 4) col = 2'd0;
            else col = 2'd1;
            colprev = col;
            @(negedge clk);
        end
        checks++;
        if (lows != P - 1) begin
            errors++;
            $display("FAIL hold_low_count got=%0d expected %0d", lows, P - 1);
        end
    endtask

    task automatic test_scan();
        logic [0:3] exp;
        logic [1:0] colprev;
        wait_idle();
        col = 2'd0;
        colprev = col;
        start_press(4'hA);
        for (int k = 1; k <= P + OFF + 3; k++) begin
            exp = (held(k - 1) && colprev == 2'd0) ? 4'b1110 : 4'b1111;
            if (!in_bounce(k - 1)) begin
                checks++;
                if (row !== exp) begin
                    errors++;
                    $display("FAIL scan_row k=%0d col_prev=%0d row=%b expected %b", k, colprev, row, exp);
                end
            end
            col = 2'(k % 4);
            colprev = col;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        seen = 1'b0;
        wait_idle();
        col = 2'd1;
        start_press(4'h5);
        for (int k = 1; k <= P + OFF + 1; k++) begin
            if (k >= 2) begin
                checks++;
                if (!in_bounce(k - 1) && row !== 4'b1011) begin
                    errors++;
                    $display("FAIL busy_ignore_row k=%0d row=%b expected 1011", k, row);
                end
                if (key_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ignore_ready k=%0d key_ready=%b expected 0", k, key_ready);
                end
            end
            if (k == 2) begin
                key_valid = 1'b1;
                key_code  = 4'hC;
            end
            if (k == 5) key_code = 4'hF;
            @(negedge clk);
        end
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_done_timeout done=%b expected 1", done);
        end
        @(negedge clk);
        checks++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle key_ready=%b busy=%b expected 1/0", key_ready, busy);
        end
        @(negedge clk);
        key_valid = 1'b0;
        checks++;
        if (key_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept key_ready=%b busy=%b expected 0/1", key_ready, busy);
        end
        col = 2'd3;
        repeat (OFF + 2) @(negedge clk);
        checks++;
        if (row !== row_for(15, 3)) begin
            errors++;
            $display("FAIL b2b_key_f row=%b expected %b", row, row_for(15, 3));
        end
    endtask

    task automatic test_timing();
        bit exp_done;
        bit exp_busy;
        wait_idle();
        col = 2'd2;
        start_press(4'h2);
        for (int k = 1; k <= TOT + 2; k++) begin
            exp_done = (k == TOT);
            exp_busy = (k <= TOT);
            checks++;
            if (done !== exp_done || busy !== exp_busy || key_ready !== !exp_busy) begin
                errors++;
                $display("FAIL timing k=%0d done=%b busy=%b ready=%b expected %b/%b/%b",
                         k, done, busy, key_ready, exp_done, exp_busy, !exp_busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_all_codes();
        logic [1:0] colprev;
        int hits;
        int zeros;
        int ridx;
        int decoded;
        for (int code = 0; code < 16; code++) begin
            wait_idle();
            col = 2'd0;
            colprev = col;
            hits = 0;
            start_press(4'(code));
            for (int k = 1; k <= P + OFF + 2; k++) begin
                if (held(k - 1) && row !== 4'b1111) begin
                    zeros = 0;
                    ridx = 0;
                    for (int r = 0; r < 4; r++) begin
                        if (row[r] === 1'b0) begin
                            zeros++;
                            ridx = r;
                        end
                    end
                    decoded = keymap[colprev][ridx];
                    hits++;
                    checks++;
                    if (zeros != 1 || decoded != code) begin
                        errors++;
                        $display("FAIL decode code=%0d row=%b col_prev=%0d decoded=%0d expected %0d",
                                 code, row, colprev, decoded, code);
                    end
                end else if (!held(k - 1) && !in_bounce(k - 1) && row !== 4'b1111) begin
                    checks++;
                    errors++;
                    $display("FAIL decode_idle_row code=%0d k=%0d row=%b expected 1111", code, k, row);
                end
                col = 2'(k % 4);
                colprev = col;
                @(negedge clk);
            end
            checks++;
            if (hits != P / 4) begin
                errors++;
                $display("FAIL decode_hits code=%0d hits=%0d expected %0d", code, hits, P / 4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_scan();
        test_back_to_back();
        test_timing();
        test_all_codes();
        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
